// File: rtl/spi_pkg.sv
// Shared SPI definitions for the board-level master and slave endpoints.
package spi_pkg;

  localparam int unsigned DATA_W_DEFAULT = 8;

  // SPI modes encoded as {CPOL, CPHA}.
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef logic [0:0] spi_state_t;
  localparam spi_state_t IDLE  = 1'b0;
  localparam spi_state_t SHIFT = 1'b1;

endpackage

// File: rtl/spi_slave_rx_tx_if.sv
// Byte-level local bus of the SPI slave. SPI_SLAVE_OVERRUN_EN adds rx_ack/rx_overrun.
interface spi_slave_rx_tx_if import spi_pkg::*; #(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) ();

  logic [DATA_W-1:0] tx_data;
  logic              tx_load;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;

`ifdef SPI_SLAVE_OVERRUN_EN
  logic rx_ack;
  logic rx_overrun;

  modport slave (
    input  tx_data, tx_load, rx_ack,
    output tx_ready, rx_data, rx_valid, busy, rx_overrun
  );
  modport master (
    output tx_data, tx_load, rx_ack,
    input  tx_ready, rx_data, rx_valid, busy, rx_overrun
  );
`else
  modport slave (
    input  tx_data, tx_load,
    output tx_ready, rx_data, rx_valid, busy
  );
  modport master (
    output tx_data, tx_load,
    input  tx_ready, rx_data, rx_valid, busy
  );
`endif

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for an asynchronous pin with rise/fall pulses from the last two samples.
module spi_sync_edge import spi_pkg::*; #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_slave_rx_tx.sv
// SPI slave: oversampled pins, MSB-first rx/tx shifting, byte-level local bus.
// Define SPI_SLAVE_OVERRUN_EN to add rx_ack/rx_overrun pending tracking.
module spi_slave_rx_tx import spi_pkg::*; #(
  parameter int unsigned DATA_W      = DATA_W_DEFAULT,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sck_in,
  input  logic                     ss_n_in,
  input  logic                     mosi_in,
  output logic                     miso_out,
  output logic                     miso_oe,
  spi_slave_rx_tx_if.slave         bus
);

  localparam int unsigned CntW = $clog2(DATA_W);

  logic sck_rise, sck_fall, sck_s_unused;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sync_sck (
    .clk(clk), .rst(rst), .d_i(sck_in),
    .q_o(sck_s_unused), .rise_o(sck_rise), .fall_o(sck_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst(rst), .d_i(ss_n_in),
    .q_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d_i(mosi_in),
    .q_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  logic lead_edge, trail_edge, sample_edge, shift_edge;
  assign lead_edge   = CPOL ? sck_fall : sck_rise;
  assign trail_edge  = CPOL ? sck_rise : sck_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;

  spi_state_t        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // MSB of an in-flight byte is never needed: completion takes {rx_shift_q, mosi_s}.
  logic [DATA_W-2:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              miso_q, miso_d;
  logic              first_q, first_d;
  logic [DATA_W-1:0] reload_val;

`ifdef SPI_SLAVE_OVERRUN_EN
  logic pending_q, pending_d;
  logic overrun_q, overrun_d;
`endif

  assign reload_val = hold_full_q ? hold_q : '0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    miso_d      = miso_q;
    first_d     = first_q;
`ifdef SPI_SLAVE_OVERRUN_EN
    pending_d   = pending_q & ~bus.rx_ack;
    overrun_d   = 1'b0;
`endif

    if (state_q == IDLE) begin
      if (ss_fall) begin
        state_d     = SHIFT;
        cnt_d       = '0;
        rx_shift_d  = '0;
        tx_shift_d  = reload_val;
        hold_full_d = 1'b0;
        first_d     = 1'b1;
        miso_d      = CPHA ? 1'b0 : reload_val[DATA_W-1];
      end
    end else if (ss_rise) begin
      // Abort or normal end: drop any partial byte, keep the holding register.
      state_d    = IDLE;
      cnt_d      = '0;
      rx_shift_d = '0;
      miso_d     = 1'b0;
      first_d    = 1'b0;
    end else begin
      if (sample_edge) begin
        rx_shift_d = {rx_shift_q[DATA_W-3:0], mosi_s};
        if (cnt_q == CntW'(DATA_W - 1)) begin
          rx_data_d  = {rx_shift_q, mosi_s};
          rx_valid_d = 1'b1;
          cnt_d      = '0;
`ifdef SPI_SLAVE_OVERRUN_EN
          overrun_d  = pending_q & ~bus.rx_ack;
          pending_d  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      if (shift_edge) begin
        if (cnt_q == '0 && !first_q) begin
          tx_shift_d  = reload_val;
          hold_full_d = 1'b0;
          miso_d      = reload_val[DATA_W-1];
        end else if (first_q && CPHA) begin
          miso_d = tx_shift_q[DATA_W-1];
        end else begin
          tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
          miso_d     = tx_shift_q[DATA_W-2];
        end
        first_d = 1'b0;
      end
    end

    // Evaluated after any reload so a same-cycle load lands behind the consumed value.
    if (bus.tx_load && !hold_full_d) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      miso_q      <= 1'b0;
      first_q     <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      miso_q      <= miso_d;
      first_q     <= first_d;
`ifdef SPI_SLAVE_OVERRUN_EN
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
`endif
    end
  end

  assign miso_out     = miso_q;
  assign miso_oe      = ~ss_s;
  assign bus.tx_ready = ~hold_full_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.busy     = (state_q == SHIFT);
`ifdef SPI_SLAVE_OVERRUN_EN
  assign bus.rx_overrun = overrun_q;
`endif

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Scoreboard bench for spi_slave_rx_tx: a mode-0 and a mode-3 instance driven by a bench SPI master.
module tb_spi_slave_rx_tx;

  localparam int H = 4;  // SCK half period in clk cycles (SCK = clk/8)

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic use3, sck_m, ss_m, mosi;
  logic sck0, ss0, sck3, ss3;
  logic miso0, oe0, miso3, oe3;

  assign sck0 = use3 ? 1'b0 : sck_m;
  assign ss0  = use3 ? 1'b1 : ss_m;
  assign sck3 = use3 ? sck_m : 1'b1;
  assign ss3  = use3 ? ss_m : 1'b1;

  spi_slave_rx_tx_if #(.DATA_W(8)) if0 ();
  spi_slave_rx_tx_if #(.DATA_W(8)) if3 ();

  spi_slave_rx_tx #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) u_dut0 (
    .clk(clk), .rst(rst), .sck_in(sck0), .ss_n_in(ss0), .mosi_in(mosi),
    .miso_out(miso0), .miso_oe(oe0), .bus(if0)
  );
  spi_slave_rx_tx #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)) u_dut3 (
    .clk(clk), .rst(rst), .sck_in(sck3), .ss_n_in(ss3), .mosi_in(mosi),
    .miso_out(miso3), .miso_oe(oe3), .bus(if3)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp0[$];
  logic [7:0] exp3[$];
  logic auto_ack = 1'b1;
  int ovr_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: pops expected bytes whenever a DUT presents rx_valid.
  always @(negedge clk) begin
    if (rst) begin
      if (if0.rx_valid) begin
        if (exp0.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rx0_spurious_valid: got rx_data %0h, required no rx_valid", if0.rx_data);
        end else check("rx0_data", 32'(if0.rx_data), 32'(exp0.pop_front()));
      end
      if (if3.rx_valid) begin
        if (exp3.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rx3_spurious_valid: got rx_data %0h, required no rx_valid", if3.rx_data);
        end else check("rx3_data", 32'(if3.rx_data), 32'(exp3.pop_front()));
      end
    end
`ifdef SPI_SLAVE_OVERRUN_EN
    if0.rx_ack = auto_ack & if0.rx_valid;
    if3.rx_ack = if3.rx_valid;
    if (rst && if0.rx_overrun) ovr_cnt++;
`endif
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] v);
    if (use3) begin if3.tx_data = v; if3.tx_load = 1'b1; end
    else begin if0.tx_data = v; if0.tx_load = 1'b1; end
    wait_clk(1);
    if0.tx_load = 1'b0;
    if3.tx_load = 1'b0;
  endtask

  // Bench master: clocks nbits of b MSB first, returns MISO bits captured.
  task automatic frame(input logic [7:0] b, input int nbits, output logic [7:0] got);
    logic [7:0] sh;
    sh  = b;
    got = '0;
    if (!use3) begin
      mosi = sh[7];
      wait_clk(H);
      for (int i = 0; i < nbits; i++) begin
        got = {got[6:0], miso0};
        sck_m = 1'b1;
        wait_clk(H);
        sck_m = 1'b0;
        sh = {sh[6:0], 1'b0};
        mosi = sh[7];
        wait_clk(H);
      end
    end else begin
      for (int i = 0; i < nbits; i++) begin
        sck_m = 1'b0;
        mosi = sh[7];
        sh = {sh[6:0], 1'b0};
        wait_clk(H);
        got = {got[6:0], miso3};
        sck_m = 1'b1;
        wait_clk(H);
      end
    end
  endtask

  logic [7:0] got;

  initial begin
    use3 = 1'b0; sck_m = 1'b0; ss_m = 1'b1; mosi = 1'b0;
    if0.tx_data = '0; if0.tx_load = 1'b0;
    if3.tx_data = '0; if3.tx_load = 1'b0;
    rst = 1'b0;
    wait_clk(3);
    check("rst_miso_out", 32'(miso0), 32'h0);
    check("rst_miso_oe", 32'(oe0), 32'h0);
    check("rst_tx_ready", 32'(if0.tx_ready), 32'h1);
    check("rst_rx_data", 32'(if0.rx_data), 32'h0);
    check("rst_rx_valid", 32'(if0.rx_valid), 32'h0);
    check("rst_busy", 32'(if0.busy), 32'h0);
    rst = 1'b1;
    wait_clk(4);

    // Mode 0 single frame with preload.
    load(8'h3C);
    check("t1_tx_ready_after_load", 32'(if0.tx_ready), 32'h0);
    exp0.push_back(8'hA5);
    ss_m = 1'b0;
    wait_clk(6);
    check("t1_tx_ready_at_ss_fall", 32'(if0.tx_ready), 32'h1);
    check("t1_busy", 32'(if0.busy), 32'h1);
    check("t1_miso_oe", 32'(oe0), 32'h1);
    frame(8'hA5, 8, got);
    check("t1_miso_byte", 32'(got), 32'h3C);
    ss_m = 1'b1;
    wait_clk(8);
    check("t1_busy_end", 32'(if0.busy), 32'h0);
    check("t1_miso_oe_end", 32'(oe0), 32'h0);

    // Back-to-back frames; 0xAA loaded after the entry reload.
    load(8'h55);
    exp0.push_back(8'h12);
    exp0.push_back(8'h34);
    ss_m = 1'b0;
    wait_clk(6);
    load(8'hAA);
    frame(8'h12, 8, got);
    check("t3_miso_frame1", 32'(got), 32'h55);
    frame(8'h34, 8, got);
    check("t3_miso_frame2", 32'(got), 32'hAA);
    ss_m = 1'b1;
    wait_clk(8);

    // Underrun: nothing loaded.
    exp0.push_back(8'h5A);
    ss_m = 1'b0;
    wait_clk(6);
    frame(8'h5A, 8, got);
    check("t4_miso_underrun", 32'(got), 32'h00);
    ss_m = 1'b1;
    wait_clk(8);

    // Abort after 5 sample edges; holding register must survive.
    ss_m = 1'b0;
    wait_clk(6);
    load(8'h99);
    frame(8'hFF, 5, got);
    ss_m = 1'b1;
    wait_clk(8);
    check("t5_busy_after_abort", 32'(if0.busy), 32'h0);
    check("t5_miso_oe_after_abort", 32'(oe0), 32'h0);
    check("t5_tx_ready_retained", 32'(if0.tx_ready), 32'h0);
    exp0.push_back(8'hC3);
    ss_m = 1'b0;
    wait_clk(6);
    frame(8'hC3, 8, got);
    check("t5_miso_after_abort", 32'(got), 32'h99);
    ss_m = 1'b1;
    wait_clk(8);

    // Mode 3.
    use3 = 1'b1; sck_m = 1'b1;
    wait_clk(4);
    load(8'h7E);
    exp3.push_back(8'h81);
    ss_m = 1'b0;
    wait_clk(6);
    check("t2_busy", 32'(if3.busy), 32'h1);
    frame(8'h81, 8, got);
    check("t2_miso_byte", 32'(got), 32'h7E);
    ss_m = 1'b1;
    wait_clk(8);
    check("t2_miso_oe_end", 32'(oe3), 32'h0);
    use3 = 1'b0; sck_m = 1'b0;
    wait_clk(4);

    // Reset after 3 bits of a frame.
    load(8'h42);
    ss_m = 1'b0;
    wait_clk(6);
    frame(8'hF0, 3, got);
    rst = 1'b0;
    wait_clk(1);
    check("t6_miso_out", 32'(miso0), 32'h0);
    check("t6_miso_oe", 32'(oe0), 32'h0);
    check("t6_tx_ready", 32'(if0.tx_ready), 32'h1);
    check("t6_rx_data", 32'(if0.rx_data), 32'h0);
    check("t6_rx_valid", 32'(if0.rx_valid), 32'h0);
    check("t6_busy", 32'(if0.busy), 32'h0);
    rst = 1'b1;
    ss_m = 1'b1;
    wait_clk(8);

`ifdef SPI_SLAVE_OVERRUN_EN
    auto_ack = 1'b0;
    exp0.push_back(8'h11);
    exp0.push_back(8'h22);
    ss_m = 1'b0;
    wait_clk(6);
    frame(8'h11, 8, got);
    frame(8'h22, 8, got);
    ss_m = 1'b1;
    wait_clk(8);
    check("ovr_pulse_count", 32'(ovr_cnt), 32'h1);
    check("ovr_rx_data", 32'(if0.rx_data), 32'h22);
`endif

    check("rx0_outstanding", 32'(exp0.size()), 32'h0);
    check("rx3_outstanding", 32'(exp3.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx_tx.md
Name: spi_slave_rx_tx

Overview:
- SPI slave endpoint; the downstream peer of the team's SPI master on the same board-level bus.
- Oversamples the external SCK/SS_n/MOSI pins in the system clock domain and deserialises MOSI into bytes.
- Serialises a preloaded transmit byte onto MISO.
- Exposes a byte-level valid/ready interface to local logic.

Parameters:
- DATA_W, 8: frame width in bits, MSB first.
- CPOL, 0: SCK idle level.
- CPHA, 0: 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge.
- SYNC_STAGES, 2: synchroniser depth on sck_in, ss_n_in and mosi_in (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 4x SCK frequency.
- rst  in  1  synchronous, active-low reset.
- sck_in  in  1  SPI clock pin, asynchronous.
- ss_n_in  in  1  slave select pin, active-low, asynchronous.
- mosi_in  in  1  master-out data pin.
- miso_out  out  1  slave-out data.
- miso_oe  out  1  MISO output enable; high while the synchronised ss_n is low.
- tx_data  in  DATA_W  byte to send next.
- tx_load  in  1  write strobe for tx_data.
- tx_ready  out  1  transmit holding register empty.
- rx_data  out  DATA_W  last complete received byte.
- rx_valid  out  1  one-cycle pulse marking new rx_data.
- busy  out  1  high in the SHIFT state.

Behaviour:
- Reset (rst=0 at posedge clk):
  - State goes to IDLE.
  - miso_out=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0.
  - Shift registers, bit counter and holding register clear. Synchroniser flops clear to the idle pin levels: sck=CPOL, ss_n=1, mosi=0.
- Synchronisation:
  - All three pins pass through SYNC_STAGES flops.
  - SCK edges are detected from the last two synchronised samples.
  - Leading edge is rising when CPOL=0 and falling when CPOL=1.
- FSM states:
  - IDLE -> SHIFT on synchronised ss_n falling.
  - SHIFT -> IDLE on synchronised ss_n rising.
  - No other states.
- Entering SHIFT:
  - Bit counter=0.
  - The holding register, or 0x00 if empty (underrun), is copied into tx_shift.
  - tx_ready goes to 1.
  - CPHA=0: miso_out = tx_shift MSB in the same cycle.
- Sample edge:
  - rx_shift <= {rx_shift[DATA_W-2:0], mosi_sync}.
  - Counter increments.
  - When the counter reaches DATA_W-1, rx_data <= the completed byte and rx_valid pulses in the next clk cycle. Latency from the pin edge is SYNC_STAGES+1 clk.
  - Counter wraps to 0.
- Shift edge:
  - tx_shift shifts left and miso_out presents the new MSB.
  - CPHA=1: the first leading edge presents the MSB instead of shifting.
  - At a byte boundary (counter=0 after a wrap), tx_shift reloads from the holding register (or 0x00) and tx_ready=1.
- Back-to-back frames without ss_n release are supported indefinitely.
- tx_load with tx_ready=1: the holding register captures tx_data and tx_ready=0.
- tx_load with tx_ready=0: ignored.
- tx_load in the same cycle as a reload: the reload consumes the old value first, then the new tx_data is captured and tx_ready=0.
- ss_n rising mid-frame (abort):
  - Partial byte discarded, no rx_valid, counter cleared, miso_oe=0 next cycle.
  - Holding register is retained.
- SCK edges while in IDLE are ignored.
- Reset mid-frame overrides everything; rx_valid is never emitted for the partial byte.

Optional Feature:
- Macro: SPI_SLAVE_OVERRUN_EN.
- Defined:
  - Adds output rx_overrun (1 bit) and input rx_ack (1 bit).
  - rx_valid sets an internal pending flag; rx_ack clears it.
  - A new byte completing while pending=1 pulses rx_overrun for 1 cycle; rx_data is still overwritten.
  - If rx_ack arrives in the same cycle as a new completion, pending stays 1 and no overrun is flagged.
- Not defined: ports absent; no pending tracking.

Decomposition:
- Package spi_pkg holds:
  - State typedef {IDLE, SHIFT}.
  - Mode constants SPI_MODE0..3 as {CPOL,CPHA}.
  - Default DATA_W localparam.
  - Shared with the master.
- Sub-module spi_sync_edge:
  - Parameterised SYNC_STAGES synchroniser plus rise/fall pulse outputs.
  - Instantiated for sck and ss_n; mosi uses the sync portion only.

Test Plan:
1. Mode 0: load tx 0x3C; master sends 0xA5 at clk/8 -> rx_data=0xA5 with a single rx_valid pulse; master captures 0x3C; tx_ready rises at ss_n fall.
2. Mode 3 (CPOL=1, CPHA=1): master sends 0x81, tx preload 0x7E -> rx_data=0x81, MISO bits 0,1,1,1,1,1,1,0.
3. Back-to-back: ss_n held low for 2 frames, 0x12 then 0x34, tx 0xAA loaded after the first reload -> two rx_valid pulses with 0x12 and 0x34; MISO sends 0xAA in the second frame.
4. Underrun: no tx_load before the frame -> MISO shifts 0x00; rx still correct.
5. Abort: ss_n rises after 5 sample edges -> no rx_valid, busy=0, counter=0; next full frame 0xC3 is received correctly.
6. Reset mid-frame after 3 bits -> all outputs at reset values next cycle. With SPI_SLAVE_OVERRUN_EN: two frames and no rx_ack -> rx_overrun pulses once, rx_data = second byte.
